// File: rtl/hwpe_engine_stream_tracker.sv
// Output-completion tracker: counts per-stream output beats against a programmed length, drives tail strobes,
// and pulses done once all streams and the kernel have finished. State and flags register in one cycle; never stalls streams.
module hwpe_engine_stream_tracker #(
    parameter int unsigned N_OUT  = 2,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned WDOG_W = 16,
    localparam int unsigned STRB_W = DATA_W / 8,
    localparam int unsigned TAIL_W = (STRB_W > 1) ? $clog2(STRB_W) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_i,
    input  logic                      start_i,
    input  logic [CNT_W-1:0]          len_i,
    input  logic [TAIL_W-1:0]         tail_bytes_i,
    input  logic [WDOG_W-1:0]         wdog_limit_i,
    input  logic [N_OUT-1:0]          out_valid_i,
    input  logic [N_OUT-1:0]          out_ready_i,
    input  logic                      kernel_done_i,
    input  logic                      kernel_ready_i,
    input  logic                      kernel_idle_i,
    output logic [N_OUT*STRB_W-1:0]   strb_o,
    output logic [N_OUT*CNT_W-1:0]    cnt_o,
    output logic                      ready_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_overrun_o,
    output logic                      err_stall_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q [N_OUT];
    logic [CNT_W-1:0]  cnt_d [N_OUT];
    logic [CNT_W-1:0]  len_q, len_d;
    logic [TAIL_W-1:0] tail_q, tail_d;
    logic [WDOG_W-1:0] wlim_q, wlim_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              done_seen_q, done_seen_d;
    logic              err_ovr_q, err_ovr_d;
    logic              err_stall_q, err_stall_d;
    logic              ready_q, ready_d;

    logic [N_OUT-1:0]  hs;
    logic [N_OUT-1:0]  at_len;
    logic              active;
    logic              any_hs;
    logic              all_at_len;
    logic              wdog_hit;
    logic [STRB_W-1:0] tail_mask;

    always_comb begin
        hs         = out_valid_i & out_ready_i;
        active     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        for (int i = 0; i < N_OUT; i++) begin
            at_len[i] = (cnt_q[i] == len_q);
        end
        all_at_len = &at_len;
        any_hs     = |hs;
        wdog_hit   = active && (wlim_q != '0) && (wdog_q == wlim_q - WDOG_W'(1));
        tail_mask  = (STRB_W'(1) << tail_q) - STRB_W'(1);
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        tail_d      = tail_q;
        wlim_d      = wlim_q;
        wdog_d      = wdog_q;
        done_seen_d = done_seen_q;
        err_ovr_d   = err_ovr_q;
        err_stall_d = err_stall_q;
        for (int i = 0; i < N_OUT; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        ready_d = (state_q == ST_IDLE) && (kernel_ready_i || kernel_idle_i);

        if (clear_i) begin
            state_d     = ST_IDLE;
            wdog_d      = '0;
            done_seen_d = 1'b0;
            err_ovr_d   = 1'b0;
            err_stall_d = 1'b0;
            for (int i = 0; i < N_OUT; i++) begin
                cnt_d[i] = '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_d     = ST_RUN;
                        len_d       = len_i;
                        tail_d      = tail_bytes_i;
                        wlim_d      = wdog_limit_i;
                        done_seen_d = 1'b0;
                        err_ovr_d   = 1'b0;
                        err_stall_d = 1'b0;
                        for (int i = 0; i < N_OUT; i++) begin
                            cnt_d[i] = '0;
                        end
                    end
                end
                ST_RUN: begin
                    // A stall abort still passes through DONE so the controller sees done_o.
                    if (wdog_hit) begin
                        state_d     = ST_DONE;
                        err_stall_d = 1'b1;
                    end else if (all_at_len) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (wdog_hit) begin
                        state_d     = ST_DONE;
                        err_stall_d = 1'b1;
                    end else if (done_seen_q) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (active) begin
                done_seen_d = done_seen_q | kernel_done_i;
                for (int i = 0; i < N_OUT; i++) begin
                    if (hs[i]) begin
                        if (cnt_q[i] < len_q) begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end else begin
                            err_ovr_d = 1'b1;
                        end
                    end
                end
            end

            if (!active || (state_d != state_q) || any_hs) begin
                wdog_d = '0;
            end else begin
                wdog_d = wdog_q + WDOG_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            tail_q      <= '0;
            wlim_q      <= '0;
            wdog_q      <= '0;
            done_seen_q <= 1'b0;
            err_ovr_q   <= 1'b0;
            err_stall_q <= 1'b0;
            ready_q     <= 1'b0;
            for (int i = 0; i < N_OUT; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            tail_q      <= tail_d;
            wlim_q      <= wlim_d;
            wdog_q      <= wdog_d;
            done_seen_q <= done_seen_d;
            err_ovr_q   <= err_ovr_d;
            err_stall_q <= err_stall_d;
            ready_q     <= ready_d;
            for (int i = 0; i < N_OUT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Only the last beat of a non-empty job gets a partial strobe.
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_out
        assign cnt_o[gi*CNT_W +: CNT_W] = cnt_q[gi];
        assign strb_o[gi*STRB_W +: STRB_W] =
            ((len_q != '0) && (tail_q != '0) && (cnt_q[gi] == len_q - CNT_W'(1))) ? tail_mask : '1;
    end

    assign ready_o       = ready_q;
    assign busy_o        = active;
    assign done_o        = (state_q == ST_DONE);
    assign err_overrun_o = err_ovr_q;
    assign err_stall_o   = err_stall_q;

endmodule

// File: tb/tb_hwpe_engine_stream_tracker.sv
// Directed bench: stimulus queues expected done records and per-beat strobes; a negedge monitor pops and compares.
module tb_hwpe_engine_stream_tracker;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        clear_i = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] len_i = '0;
    logic [1:0]  tail_bytes_i = '0;
    logic [15:0] wdog_limit_i = '0;
    logic [1:0]  out_valid_i = '0;
    logic [1:0]  out_ready_i = '0;
    logic        kernel_done_i = 1'b0;
    logic        kernel_ready_i = 1'b1;
    logic        kernel_idle_i = 1'b0;
    logic [7:0]  strb_o;
    logic [63:0] cnt_o;
    logic        ready_o, busy_o, done_o, err_overrun_o, err_stall_o;

    hwpe_engine_stream_tracker #(
        .N_OUT(2), .CNT_W(32), .DATA_W(32), .WDOG_W(16)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
        .len_i(len_i), .tail_bytes_i(tail_bytes_i), .wdog_limit_i(wdog_limit_i),
        .out_valid_i(out_valid_i), .out_ready_i(out_ready_i),
        .kernel_done_i(kernel_done_i), .kernel_ready_i(kernel_ready_i), .kernel_idle_i(kernel_idle_i),
        .strb_o(strb_o), .cnt_o(cnt_o), .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o),
        .err_overrun_o(err_overrun_o), .err_stall_o(err_stall_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] c0;
        logic [31:0] c1;
        logic        ovr;
        logic        stall;
        int          lat;
        int          sc;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] sq0[$];
    logic [3:0] sq1[$];
    exp_t       mon_e;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int last_start = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got an event, want none", nm);
    endtask

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (busy_o && out_valid_i[0] && out_ready_i[0]) begin
                if (sq0.size() == 0) flag("strb0_unexpected_beat");
                else chk("strb0", {60'd0, strb_o[3:0]}, {60'd0, sq0.pop_front()});
            end
            if (busy_o && out_valid_i[1] && out_ready_i[1]) begin
                if (sq1.size() == 0) flag("strb1_unexpected_beat");
                else chk("strb1", {60'd0, strb_o[7:4]}, {60'd0, sq1.pop_front()});
            end
            if (done_o) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    flag("unexpected_done");
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("done_cnt0", {32'd0, cnt_o[31:0]}, {32'd0, mon_e.c0});
                    chk("done_cnt1", {32'd0, cnt_o[63:32]}, {32'd0, mon_e.c1});
                    chk("done_ovr", {63'd0, err_overrun_o}, {63'd0, mon_e.ovr});
                    chk("done_stall", {63'd0, err_stall_o}, {63'd0, mon_e.stall});
                    if (mon_e.lat >= 0) chk("done_lat", 64'(cyc - mon_e.sc), 64'(mon_e.lat));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_job(input logic [31:0] len, input logic [1:0] tail, input logic [15:0] wlim);
        len_i = len;
        tail_bytes_i = tail;
        wdog_limit_i = wlim;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        last_start = cyc;
    endtask

    task automatic push_done(input logic [31:0] c0, input logic [31:0] c1, input logic ovr,
                             input logic stall, input int lat);
        exp_t e;
        e.c0 = c0; e.c1 = c1; e.ovr = ovr; e.stall = stall; e.lat = lat; e.sc = last_start;
        exp_q.push_back(e);
    endtask

    task automatic push_strb(input int n, input logic [3:0] last_v);
        for (int k = 0; k < n; k++) begin
            sq0.push_back((k == n - 1) ? last_v : 4'hF);
            sq1.push_back((k == n - 1) ? last_v : 4'hF);
        end
    endtask

    task automatic wait_done(input int target);
        for (int k = 0; k < 100; k++) begin
            if (done_cnt >= target) break;
            tick();
        end
        total++;
        if (done_cnt < target) begin
            bad++;
            $display("FAIL wait_done: got %0d done pulses, want %0d", done_cnt, target);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_done"}, {63'd0, done_o}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy_o}, 64'd0);
        chk({tag, "_ready"}, {63'd0, ready_o}, 64'd0);
        chk({tag, "_cnt"}, cnt_o, 64'd0);
        chk({tag, "_strb"}, {56'd0, strb_o}, 64'hFF);
        chk({tag, "_ovr"}, {63'd0, err_overrun_o}, 64'd0);
        chk({tag, "_stall"}, {63'd0, err_stall_o}, 64'd0);
    endtask

    initial begin
        tick();
        tick();
        chk_reset_vals("reset");
        rst_ni = 1'b1;
        out_ready_i = 2'b11;
        tick();
        chk("ready_idle", {63'd0, ready_o}, 64'd1);

        // Full beats, kernel done arrives in DRAIN.
        start_job(32'd4, 2'd0, 16'd0);
        push_done(32'd4, 32'd4, 1'b0, 1'b0, 7);
        push_strb(4, 4'hF);
        out_valid_i = 2'b11;
        tick();
        chk("ready_busy", {63'd0, ready_o}, 64'd0);
        repeat (3) tick();
        out_valid_i = 2'b00;
        tick();
        kernel_done_i = 1'b1;
        tick();
        kernel_done_i = 1'b0;
        wait_done(1);

        // Partial last beat: two valid bytes.
        start_job(32'd3, 2'd2, 16'd0);
        push_done(32'd3, 32'd3, 1'b0, 1'b0, -1);
        push_strb(3, 4'b0011);
        out_valid_i = 2'b11;
        repeat (3) tick();
        out_valid_i = 2'b00;
        kernel_done_i = 1'b1;
        tick();
        kernel_done_i = 1'b0;
        wait_done(2);
        tick();
        chk("strb_after_job", {56'd0, strb_o}, 64'hFF);

        // Early kernel done while stream1 stalls.
        start_job(32'd4, 2'd0, 16'd0);
        push_done(32'd4, 32'd4, 1'b0, 1'b0, -1);
        push_strb(4, 4'hF);
        out_valid_i = 2'b01;
        kernel_done_i = 1'b1;
        tick();
        kernel_done_i = 1'b0;
        repeat (3) tick();
        out_valid_i = 2'b00;
        repeat (6) tick();
        chk("early_kdone_busy", {63'd0, busy_o}, 64'd1);
        chk("early_kdone_nodone", 64'(done_cnt), 64'd2);
        out_valid_i = 2'b10;
        repeat (4) tick();
        out_valid_i = 2'b00;
        wait_done(3);

        // Overrun: third beat on stream0 with len=2.
        start_job(32'd2, 2'd0, 16'd0);
        push_done(32'd2, 32'd2, 1'b1, 1'b0, -1);
        sq0.push_back(4'hF); sq0.push_back(4'hF); sq0.push_back(4'hF);
        sq1.push_back(4'hF); sq1.push_back(4'hF);
        out_valid_i = 2'b11;
        repeat (2) tick();
        out_valid_i = 2'b01;
        tick();
        out_valid_i = 2'b00;
        chk("ovr_flag", {63'd0, err_overrun_o}, 64'd1);
        chk("ovr_cnt0_sat", {32'd0, cnt_o[31:0]}, 64'd2);
        kernel_done_i = 1'b1;
        tick();
        kernel_done_i = 1'b0;
        wait_done(4);
        tick();
        chk("ovr_sticky", {63'd0, err_overrun_o}, 64'd1);

        // Watchdog abort, limit 8, no beats.
        start_job(32'd4, 2'd0, 16'd8);
        push_done(32'd0, 32'd0, 1'b0, 1'b1, 8);
        wait_done(5);
        tick();
        tick();
        chk("wdog_ready", {63'd0, ready_o}, 64'd1);
        chk("wdog_stall_sticky", {63'd0, err_stall_o}, 64'd1);
        chk("wdog_idle", {63'd0, busy_o}, 64'd0);

        // Clear with start in RUN.
        start_job(32'd4, 2'd0, 16'd0);
        chk("start_clears_stall", {63'd0, err_stall_o}, 64'd0);
        tick();
        push_strb(1, 4'hF);
        out_valid_i = 2'b11;
        tick();
        out_valid_i = 2'b00;
        chk("pre_clear_cnt", cnt_o, {32'd1, 32'd1});
        clear_i = 1'b1;
        start_i = 1'b1;
        tick();
        clear_i = 1'b0;
        start_i = 1'b0;
        chk("clear_busy", {63'd0, busy_o}, 64'd0);
        chk("clear_cnt", cnt_o, 64'd0);
        tick();
        chk("clear_start_ignored", {63'd0, busy_o}, 64'd0);
        repeat (3) tick();

        // Asynchronous reset mid-RUN.
        start_job(32'd4, 2'd0, 16'd0);
        push_strb(2, 4'hF);
        out_valid_i = 2'b11;
        repeat (2) tick();
        out_valid_i = 2'b00;
        #2;
        rst_ni = 1'b0;
        #1;
        chk_reset_vals("midrun_reset");
        tick();
        rst_ni = 1'b1;
        repeat (3) tick();
        chk("reset_no_done", 64'(done_cnt), 64'd5);

        // Zero-length job: done tracks kernel done.
        start_job(32'd0, 2'd3, 16'd0);
        push_done(32'd0, 32'd0, 1'b0, 1'b0, -1);
        repeat (2) tick();
        chk("len0_busy", {63'd0, busy_o}, 64'd1);
        chk("len0_strb", {56'd0, strb_o}, 64'hFF);
        chk("len0_nodone", 64'(done_cnt), 64'd5);
        kernel_done_i = 1'b1;
        tick();
        kernel_done_i = 1'b0;
        wait_done(6);

        repeat (3) tick();
        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
        chk("sq0_empty", 64'(sq0.size()), 64'd0);
        chk("sq1_empty", 64'(sq1.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
